alu_rr_arbiter: RTL and testbench

//  Shares one combinational ALU (and/or/add/mul/sub/slt, 4-bit ctrl) between two

---
 rtl/alu_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: lets two requesters share one combinational ALU.
// A round-robin arbiter picks one valid request while idle and registers its
// operands toward the ALU. After EXEC_CYCLES the ALU outputs are captured into
// a response that is held until the consumer takes it.
module alu_rr_arbiter #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_greater_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_greater_o,
  output logic              busy_o
);

  // The counter only has to hold EXEC_CYCLES-1, never less than one bit wide.
  localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_grant_r;
  logic               grant_valid_s;
  logic               grant_id_s;
  logic               accept_s;
  logic               capture_s;
  logic               release_s;

  logic [DATA_W-1:0]  alu_src1_r;
  logic [DATA_W-1:0]  alu_src2_r;
  logic [CTRL_W-1:0]  alu_ctrl_r;
  logic               rsp_valid_r;
  logic               rsp_id_r;
  logic [DATA_W-1:0]  rsp_result_r;
  logic               rsp_zero_r;
  logic               rsp_greater_r;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_grant_r;
    end else if (req0_valid_i) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_valid_i) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign accept_s     = (state_r == ST_IDLE) && grant_valid_s;
  assign req0_ready_o = accept_s && !grant_id_s;
  assign req1_ready_o = accept_s && grant_id_s;

  // Next-state logic plus the one-cycle capture/release strobes.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (rsp_valid_r && rsp_ready_i) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand registers toward the ALU, owner id, round-robin history and hold counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_src1_r   <= {DATA_W{1'b0}};
      alu_src2_r   <= {DATA_W{1'b0}};
      alu_ctrl_r   <= {CTRL_W{1'b0}};
      rsp_id_r     <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        if (grant_id_s) begin
          alu_src1_r <= req1_src1_i;
          alu_src2_r <= req1_src2_i;
          alu_ctrl_r <= req1_ctrl_i;
        end else begin
          alu_src1_r <= req0_src1_i;
          alu_src2_r <= req0_src2_i;
          alu_ctrl_r <= req0_ctrl_i;
        end
        rsp_id_r     <= grant_id_s;
        last_grant_r <= grant_id_s;
        cnt_r        <= CNT_LOAD;
      end else if ((state_r == ST_EXEC) && !capture_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

  // Response registers: capture the ALU outputs once, hold until taken.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_valid_r   <= 1'b0;
      rsp_result_r  <= {DATA_W{1'b0}};
      rsp_zero_r    <= 1'b0;
      rsp_greater_r <= 1'b0;
    end else begin
      if (capture_s) begin
        rsp_valid_r   <= 1'b1;
        rsp_result_r  <= alu_result_i;
        rsp_zero_r    <= alu_zero_i;
        rsp_greater_r <= alu_greater_i;
      end else if (release_s) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign alu_src1_o    = alu_src1_r;
  assign alu_src2_o    = alu_src2_r;
  assign alu_ctrl_o    = alu_ctrl_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_id_o      = rsp_id_r;
  assign rsp_result_o  = rsp_result_r;
  assign rsp_zero_o    = rsp_zero_r;
  assign rsp_greater_o = rsp_greater_r;
  assign busy_o        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: expected responses are queued when a
// request is issued and a monitor pops them as the DUT hands responses over.
// Instance a uses EXEC_CYCLES=1, instance b uses EXEC_CYCLES=3.
module tb_alu_rr_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
    logic          gt;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance a signals
  logic          r0_valid, r1_valid, rdy0, rdy1;
  logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [CW-1:0] r0_c, r1_c;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [CW-1:0] alu_c;
  logic          alu_z, alu_g;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_g, busy;
  logic [DW-1:0] rsp_res;

  // instance b signals
  logic          b_r0_valid, b_r1_valid, b_rdy0, b_rdy1;
  logic [DW-1:0] b_r0_a, b_r0_b, b_r1_a, b_r1_b;
  logic [CW-1:0] b_r0_c, b_r1_c;
  logic [DW-1:0] b_alu_a, b_alu_b, b_alu_res;
  logic [CW-1:0] b_alu_c;
  logic          b_alu_z, b_alu_g;
  logic          b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_z, b_rsp_g, b_busy;
  logic [DW-1:0] b_rsp_res;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  rsp_t exp_q[$];
  rsp_t exp_b_q[$];

  alu_rr_arbiter #(.DATA_W(DW), .CTRL_W(CW), .EXEC_CYCLES(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(r0_valid), .req0_ready_o(rdy0), .req0_src1_i(r0_a), .req0_src2_i(r0_b), .req0_ctrl_i(r0_c),
    .req1_valid_i(r1_valid), .req1_ready_o(rdy1), .req1_src1_i(r1_a), .req1_src2_i(r1_b), .req1_ctrl_i(r1_c),
    .alu_src1_o(alu_a), .alu_src2_o(alu_b), .alu_ctrl_o(alu_c),
    .alu_result_i(alu_res), .alu_zero_i(alu_z), .alu_greater_i(alu_g),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_res), .rsp_zero_o(rsp_z), .rsp_greater_o(rsp_g), .busy_o(busy)
  );

  alu_rr_arbiter #(.DATA_W(DW), .CTRL_W(CW), .EXEC_CYCLES(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(b_r0_valid), .req0_ready_o(b_rdy0), .req0_src1_i(b_r0_a), .req0_src2_i(b_r0_b), .req0_ctrl_i(b_r0_c),
    .req1_valid_i(b_r1_valid), .req1_ready_o(b_rdy1), .req1_src1_i(b_r1_a), .req1_src2_i(b_r1_b), .req1_ctrl_i(b_r1_c),
    .alu_src1_o(b_alu_a), .alu_src2_o(b_alu_b), .alu_ctrl_o(b_alu_c),
    .alu_result_i(b_alu_res), .alu_zero_i(b_alu_z), .alu_greater_i(b_alu_g),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_id_o(b_rsp_id),
    .rsp_result_o(b_rsp_res), .rsp_zero_o(b_rsp_z), .rsp_greater_o(b_rsp_g), .busy_o(b_busy)
  );

  // Reference ALU: and/or/add/mul/sub/slt, anything else returns 0.
  function automatic logic [DW-1:0] alu_f(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a * b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_res   = alu_f(alu_c, alu_a, alu_b);
    alu_z     = (alu_res == 32'd0);
    alu_g     = (alu_a > alu_b);
    b_alu_res = alu_f(b_alu_c, b_alu_a, b_alu_b);
    b_alu_z   = (b_alu_res == 32'd0);
    b_alu_g   = (b_alu_a > b_alu_b);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance a: pop and compare on every response handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0b result=0x%0h expected no response", rsp_id, rsp_res);
      end else begin
        e = exp_q.pop_front();
        chk1("rsp_id", rsp_id, e.id);
        chk32("rsp_result", rsp_res, e.res);
        chk1("rsp_zero", rsp_z, e.zero);
        chk1("rsp_greater", rsp_g, e.gt);
      end
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && b_rsp_valid && b_rsp_ready) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_rsp_unexpected: got result=0x%0h expected no response", b_rsp_res);
      end else begin
        e = exp_b_q.pop_front();
        chk1("b_rsp_id", b_rsp_id, e.id);
        chk32("b_rsp_result", b_rsp_res, e.res);
        chk1("b_rsp_zero", b_rsp_z, e.zero);
        chk1("b_rsp_greater", b_rsp_g, e.gt);
      end
    end
  end

  // Never two readys in the same cycle.
  always @(negedge clk) begin
    if (rst_n) chk1("one_ready", rdy0 & rdy1, 1'b0);
  end

  // Issue one request on instance a; returns 1 time unit after the accept edge.
  task automatic send(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [CW-1:0] c, input logic push, input rsp_t e);
    logic got;
    got = 1'b0;
    if (push) exp_q.push_back(e);
    if (id) begin
      r1_a = a; r1_b = b; r1_c = c; r1_valid = 1'b1;
    end else begin
      r0_a = a; r0_b = b; r0_c = c; r0_valid = 1'b1;
    end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = id ? rdy1 : rdy0;
    end
    chk1("send_grant", got, 1'b1);
    @(posedge clk); #1;
    if (id) r1_valid = 1'b0;
    else    r0_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    for (int t = 0; t < 30 && (busy || rsp_valid); t++) @(negedge clk);
    chk1("idle_timeout", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic gseq [4];
    int   gcyc [4];
    int   ng;
    logic got;

    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
    r0_a = 32'd0; r0_b = 32'd0; r0_c = 4'd0; r1_a = 32'd0; r1_b = 32'd0; r1_c = 4'd0;
    b_r0_valid = 1'b0; b_r1_valid = 1'b0; b_rsp_ready = 1'b1;
    b_r0_a = 32'd0; b_r0_b = 32'd0; b_r0_c = 4'd0; b_r1_a = 32'd0; b_r1_b = 32'd0; b_r1_c = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_alu_src1", alu_a, 32'd0);
    chk32("rst_alu_ctrl", DW'(alu_c), 32'd0);
    chk32("rst_rsp_result", rsp_res, 32'd0);
    chk1("rst_b_busy", b_busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // T1: req0 AND, one-cycle latency
    @(posedge clk); #1;
    send(1'b0, 32'hF0F0_0000, 32'hFF00_FF00, 4'b0000, 1'b1, '{1'b0, 32'hF000_0000, 1'b0, 1'b0});
    @(negedge clk);
    chk1("t1_not_yet_valid", rsp_valid, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    chk32("t1_alu_src1", alu_a, 32'hF0F0_0000);
    chk32("t1_alu_src2", alu_b, 32'hFF00_FF00);
    @(negedge clk);
    chk1("t1_valid_after_1", rsp_valid, 1'b1);
    wait_idle_a();

    // T2: req1 SUB 5-5
    send(1'b1, 32'd5, 32'd5, 4'b0110, 1'b1, '{1'b1, 32'd0, 1'b1, 1'b0});
    wait_idle_a();

    // T3: both valid continuously after reset -> 0,1,0,1, issue interval 3
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back('{1'b0, 32'd3, 1'b0, 1'b0});
    exp_q.push_back('{1'b1, 32'd15, 1'b0, 1'b1});
    exp_q.push_back('{1'b0, 32'd3, 1'b0, 1'b0});
    exp_q.push_back('{1'b1, 32'd15, 1'b0, 1'b1});
    r0_a = 32'd1;  r0_b = 32'd2; r0_c = 4'b0010;
    r1_a = 32'd10; r1_b = 32'd5; r1_c = 4'b0001;
    r0_valid = 1'b1; r1_valid = 1'b1;
    ng = 0;
    for (int t = 0; t < 40 && ng < 4; t++) begin
      @(negedge clk);
      if (rdy0 || rdy1) begin
        gseq[ng] = rdy1;
        gcyc[ng] = cyc;
        ng++;
      end
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk32("t3_grant_count", DW'(ng), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk1("t3_order", gseq[i], (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i > 0) chk32("t3_interval", DW'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    wait_idle_a();

    // T4: consumer stalls 5 cycles in RESP while req1 waits
    rsp_ready = 1'b0;
    send(1'b0, 32'hA, 32'h3, 4'b0110, 1'b1, '{1'b0, 32'd7, 1'b0, 1'b1});
    exp_q.push_back('{1'b1, 32'd1, 1'b0, 1'b0});
    r1_a = 32'd2; r1_b = 32'd9; r1_c = 4'b0111; r1_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk1("t4_rsp_seen", got, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk1("t4_hold_valid", rsp_valid, 1'b1);
      chk32("t4_hold_result", rsp_res, 32'd7);
      chk1("t4_hold_id", rsp_id, 1'b0);
      chk1("t4_hold_greater", rsp_g, 1'b1);
      chk1("t4_rdy0_low", rdy0, 1'b0);
      chk1("t4_rdy1_low", rdy1, 1'b0);
      chk1("t4_busy", busy, 1'b1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("t4_idle_next", busy, 1'b0);
    chk1("t4_rdy1_next", rdy1, 1'b1);
    @(posedge clk); #1 r1_valid = 1'b0;
    wait_idle_a();

    // T5: reset during EXEC drops the op; next tie goes to req0
    send(1'b0, 32'h1234, 32'h1, 4'b0010, 1'b0, '{1'b0, 32'd0, 1'b0, 1'b0});
    chk1("t5_in_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t5_rst_valid", rsp_valid, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk32("t5_rst_alu_src1", alu_a, 32'd0);
    chk32("t5_rst_alu_src2", alu_b, 32'd0);
    chk32("t5_rst_alu_ctrl", DW'(alu_c), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk1("t5_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    exp_q.push_back('{1'b0, 32'd0, 1'b1, 1'b0});
    exp_q.push_back('{1'b1, 32'd0, 1'b1, 1'b1});
    r0_a = 32'h0F; r0_b = 32'hF0; r0_c = 4'b0000;
    r1_a = 32'hFFFF_FFFF; r1_b = 32'd1; r1_c = 4'b0010;
    r0_valid = 1'b1; r1_valid = 1'b1;
    @(negedge clk);
    chk1("t5_tie_rdy0", rdy0, 1'b1);
    chk1("t5_tie_rdy1", rdy1, 1'b0);
    @(posedge clk); #1 r0_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = rdy1;
    end
    chk1("t5_req1_grant", got, 1'b1);
    @(posedge clk); #1 r1_valid = 1'b0;
    wait_idle_a();

    // T6: EXEC_CYCLES=3, 7*6 captured 3 edges after accept, operands stable
    exp_b_q.push_back('{1'b0, 32'd42, 1'b0, 1'b1});
    b_r0_a = 32'd7; b_r0_b = 32'd6; b_r0_c = 4'b0011; b_r0_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = b_rdy0;
    end
    chk1("t6_grant", got, 1'b1);
    @(posedge clk); #1 b_r0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t6_latency", b_rsp_valid, (i == 3) ? 1'b1 : 1'b0);
      chk32("t6_alu_src1", b_alu_a, 32'd7);
      chk32("t6_alu_src2", b_alu_b, 32'd6);
      chk32("t6_alu_ctrl", DW'(b_alu_c), 32'd3);
    end
    for (int t = 0; t < 20 && b_busy; t++) @(negedge clk);
    chk1("t6_idle", b_busy, 1'b0);

    repeat (3) @(negedge clk);
    chk32("a_queue_drained", DW'(exp_q.size()), 32'd0);
    chk32("b_queue_drained", DW'(exp_b_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
